bsram_port_ctrl: RTL and testbench

//  Owns the 8 KB Gowin_SDPB (simple dual-port BSRAM) and sequences it. After reset, the boot phase streams a program image into the write port from BOOT_BASE upward.
//  In the run phase the write port passes through to the CPU, and the read port is shared round-robin between the CPU and the LCD fetcher.

---
 rtl/bsram_port_ctrl_pkg.sv | 8 +
 rtl/bsram_port_ctrl_rr_arb2.sv | 34 +++
 rtl/bsram_port_ctrl.sv | 160 ++++++++++++++++
 tb/tb_bsram_port_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsram_port_ctrl_pkg.sv
// Shared types and default geometry for the BSRAM port controller.
package bsram_ctrl_pkg;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;

   typedef enum logic {ST_BOOT, ST_RUN} state_t;
   typedef enum logic {REQ_CPU, REQ_LCD} req_id_t;
endpackage

// File: rtl/bsram_port_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the CPU, bit 1 the LCD fetcher.
module rr_arb2
   import bsram_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   req_id_t last_q, last_d;

   always_comb begin
      gnt    = 2'b00;
      last_d = last_q;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         // Contention: hand the port to whoever lost last time.
         2'b11:   gnt = (last_q == REQ_LCD) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
      if (gnt != 2'b00) begin
         last_d = gnt[1] ? REQ_LCD : REQ_CPU;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= REQ_CPU;
      end else begin
         last_q <= last_d;
      end
   end
endmodule

// File: rtl/bsram_port_ctrl.sv
// Sequences the simple dual-port BSRAM: boot image load, then CPU writes
// plus a shared CPU/LCD read port with tagged, fixed-latency returns.
module bsram_port_ctrl #(
   parameter int                ADDR_W       = bsram_ctrl_pkg::ADDR_W,
   parameter int                DATA_W       = bsram_ctrl_pkg::DATA_W,
   parameter logic [ADDR_W-1:0] BOOT_BASE    = '0,
   parameter int                READ_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              boot_valid,
   output logic              boot_ready,
   input  logic [DATA_W-1:0] boot_data,
   input  logic              boot_last,
   output logic              boot_done,
   output logic              boot_ovf,
   input  logic              cpu_wr_en,
   input  logic [ADDR_W-1:0] cpu_wr_addr,
   input  logic [DATA_W-1:0] cpu_wr_data,
   input  logic              cpu_rd_req,
   input  logic [ADDR_W-1:0] cpu_rd_addr,
   output logic              cpu_rd_gnt,
   output logic              cpu_rd_valid,
   output logic [DATA_W-1:0] cpu_rd_data,
   input  logic              lcd_rd_req,
   input  logic [ADDR_W-1:0] lcd_rd_addr,
   output logic              lcd_rd_gnt,
   output logic              lcd_rd_valid,
   output logic [DATA_W-1:0] lcd_rd_data,
   output logic              mem_cea,
   output logic [ADDR_W-1:0] mem_ada,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_ceb,
   output logic [ADDR_W-1:0] mem_adb,
   output logic              mem_oce,
   input  logic [DATA_W-1:0] mem_dout
);
   import bsram_ctrl_pkg::*;

   localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] boot_addr_q, boot_addr_d;
   logic              boot_done_q;
   logic              boot_ovf_q, boot_ovf_d;
   logic              boot_at_top;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [1:0]        rd_req, rd_gnt;
   logic              pipe_v_q  [READ_LATENCY];
   req_id_t           pipe_id_q [READ_LATENCY];
   logic              ret_v;
   req_id_t           ret_id;
   logic [DATA_W-1:0] cpu_hold_q, lcd_hold_q;

   always_comb begin
      state_d     = state_q;
      boot_addr_d = boot_addr_q;
      boot_ovf_d  = boot_ovf_q;
      boot_ready  = 1'b0;
      boot_at_top = (boot_addr_q == ADDR_TOP);
      wr_en_d     = cpu_wr_en;
      wr_addr_d   = cpu_wr_addr;
      wr_data_d   = cpu_wr_data;
      case (state_q)
         ST_BOOT: begin
            boot_ready = 1'b1;
            wr_en_d    = boot_valid;
            wr_addr_d  = boot_addr_q;
            wr_data_d  = boot_data;
            if (boot_valid) begin
               // Top of memory ends boot even without last; the counter never wraps.
               if (boot_last || boot_at_top) begin
                  state_d    = ST_RUN;
                  boot_ovf_d = !boot_last;
               end else begin
                  boot_addr_d = boot_addr_q + ADDR_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_BOOT;
         boot_addr_q <= BOOT_BASE;
         boot_done_q <= 1'b0;
         boot_ovf_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         boot_addr_q <= boot_addr_d;
         boot_done_q <= (state_q == ST_RUN);
         boot_ovf_q  <= boot_ovf_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign boot_done = boot_done_q;
   assign boot_ovf  = boot_ovf_q;
   assign mem_cea   = wr_en_q;
   assign mem_ada   = wr_addr_q;
   assign mem_din   = wr_data_q;

   assign rd_req = {lcd_rd_req, cpu_rd_req} & {2{rst_n && (state_q == ST_RUN)}};

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (rd_req),
      .gnt   (rd_gnt)
   );

   assign cpu_rd_gnt = rd_gnt[0];
   assign lcd_rd_gnt = rd_gnt[1];
   assign mem_ceb    = |rd_gnt;
   assign mem_adb    = rd_gnt[1] ? lcd_rd_addr : cpu_rd_addr;
   assign mem_oce    = (READ_LATENCY == 2);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_v_q[i]  <= 1'b0;
            pipe_id_q[i] <= REQ_CPU;
         end
      end else begin
         for (int i = READ_LATENCY - 1; i > 0; i--) begin
            pipe_v_q[i]  <= pipe_v_q[i-1];
            pipe_id_q[i] <= pipe_id_q[i-1];
         end
         pipe_v_q[0]  <= |rd_gnt;
         pipe_id_q[0] <= rd_gnt[1] ? REQ_LCD : REQ_CPU;
      end
   end

   // The pipe tail lines up with mem_dout, so the data path is a bypass mux.
   assign ret_v        = rst_n && pipe_v_q[READ_LATENCY-1];
   assign ret_id       = pipe_id_q[READ_LATENCY-1];
   assign cpu_rd_valid = ret_v && (ret_id == REQ_CPU);
   assign lcd_rd_valid = ret_v && (ret_id == REQ_LCD);
   assign cpu_rd_data  = cpu_rd_valid ? mem_dout : cpu_hold_q;
   assign lcd_rd_data  = lcd_rd_valid ? mem_dout : lcd_hold_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cpu_hold_q <= '0;
         lcd_hold_q <= '0;
      end else begin
         if (cpu_rd_valid) cpu_hold_q <= mem_dout;
         if (lcd_rd_valid) lcd_hold_q <= mem_dout;
      end
   end
endmodule

// File: tb/tb_bsram_port_ctrl.sv
// Directed bench for bsram_port_ctrl with a pipelined BSRAM model attached.
module tb_bsram_port_ctrl;
   localparam int AW = 13;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          boot_valid, boot_ready, boot_last, boot_done, boot_ovf;
   logic [DW-1:0] boot_data;
   logic          cpu_wr_en;
   logic [AW-1:0] cpu_wr_addr;
   logic [DW-1:0] cpu_wr_data;
   logic          cpu_rd_req, cpu_rd_gnt, cpu_rd_valid;
   logic [AW-1:0] cpu_rd_addr;
   logic [DW-1:0] cpu_rd_data;
   logic          lcd_rd_req, lcd_rd_gnt, lcd_rd_valid;
   logic [AW-1:0] lcd_rd_addr;
   logic [DW-1:0] lcd_rd_data;
   logic          mem_cea, mem_ceb, mem_oce;
   logic [AW-1:0] mem_ada, mem_adb;
   logic [DW-1:0] mem_din, mem_dout;

   logic          b_valid, b_ready, b_last, b_done, b_ovf;
   logic [DW-1:0] b_data;
   logic          b_cpu_gnt, b_cpu_valid, b_lcd_gnt, b_lcd_valid;
   logic [DW-1:0] b_cpu_data, b_lcd_data;
   logic          b_cea, b_ceb, b_oce;
   logic [AW-1:0] b_ada, b_adb;
   logic [DW-1:0] b_din;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   bsram_port_ctrl u_dut (
      .clk(clk), .rst_n(rst_n),
      .boot_valid(boot_valid), .boot_ready(boot_ready), .boot_data(boot_data),
      .boot_last(boot_last), .boot_done(boot_done), .boot_ovf(boot_ovf),
      .cpu_wr_en(cpu_wr_en), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
      .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_gnt(cpu_rd_gnt),
      .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
      .lcd_rd_req(lcd_rd_req), .lcd_rd_addr(lcd_rd_addr), .lcd_rd_gnt(lcd_rd_gnt),
      .lcd_rd_valid(lcd_rd_valid), .lcd_rd_data(lcd_rd_data),
      .mem_cea(mem_cea), .mem_ada(mem_ada), .mem_din(mem_din),
      .mem_ceb(mem_ceb), .mem_adb(mem_adb), .mem_oce(mem_oce), .mem_dout(mem_dout)
   );

   bsram_port_ctrl #(.BOOT_BASE(13'h1FFE)) u_dut_top (
      .clk(clk), .rst_n(rst_n),
      .boot_valid(b_valid), .boot_ready(b_ready), .boot_data(b_data),
      .boot_last(b_last), .boot_done(b_done), .boot_ovf(b_ovf),
      .cpu_wr_en(1'b0), .cpu_wr_addr('0), .cpu_wr_data('0),
      .cpu_rd_req(1'b0), .cpu_rd_addr('0), .cpu_rd_gnt(b_cpu_gnt),
      .cpu_rd_valid(b_cpu_valid), .cpu_rd_data(b_cpu_data),
      .lcd_rd_req(1'b0), .lcd_rd_addr('0), .lcd_rd_gnt(b_lcd_gnt),
      .lcd_rd_valid(b_lcd_valid), .lcd_rd_data(b_lcd_data),
      .mem_cea(b_cea), .mem_ada(b_ada), .mem_din(b_din),
      .mem_ceb(b_ceb), .mem_adb(b_adb), .mem_oce(b_oce), .mem_dout(8'h00)
   );

   // BSRAM in pipeline mode: array read on ceb, output register on oce.
   logic [DW-1:0] mem [1 << AW];
   logic [DW-1:0] rd_stage, dout_q;
   always @(posedge clk) begin
      if (mem_cea) mem[mem_ada] <= mem_din;
      if (mem_ceb) rd_stage <= mem[mem_adb];
      if (mem_oce) dout_q <= rd_stage;
   end
   assign mem_dout = dout_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic cg, lg, cv, lv;
      int   g;
      rst_n = 1'b0;
      boot_valid = 0; boot_data = 0; boot_last = 0;
      cpu_wr_en = 0; cpu_wr_addr = 0; cpu_wr_data = 0;
      cpu_rd_req = 1; cpu_rd_addr = 0; lcd_rd_req = 0; lcd_rd_addr = 0;
      b_valid = 0; b_data = 0; b_last = 0;
      step; step;
      @(negedge clk);
      chk("rst_ready", boot_ready, 1);
      chk("rst_done", boot_done, 0);
      chk("rst_ovf", boot_ovf, 0);
      chk("rst_cea", mem_cea, 0);
      chk("rst_ceb", mem_ceb, 0);
      chk("rst_cpu_gnt", cpu_rd_gnt, 0);
      chk("rst_cpu_valid", cpu_rd_valid, 0);
      chk("rst_cpu_data", cpu_rd_data, 0);
      chk("rst_lcd_data", lcd_rd_data, 0);
      chk("rst_oce", mem_oce, 1);
      chk("rst_b_ovf", b_ovf, 0);
      step;
      rst_n = 1'b1;
      cpu_rd_req = 0;

      // 1: boot 06..09 while CPU writes are attempted and must be dropped
      for (int i = 0; i < 4; i++) begin
         boot_valid = 1; boot_data = DW'(8'h06 + i); boot_last = (i == 3);
         cpu_wr_en = 1; cpu_wr_addr = AW'(i); cpu_wr_data = 8'hEE;
         @(negedge clk);
         chk("t1_ready", boot_ready, 1);
         if (i > 0) begin
            chk("t1_cea", mem_cea, 1);
            chk("t1_ada", mem_ada, i - 1);
            chk("t1_din", mem_din, 8'h06 + i - 1);
         end else begin
            chk("t1_cea0", mem_cea, 0);
         end
         step;
      end
      boot_valid = 0; boot_last = 0; cpu_wr_en = 0;
      @(negedge clk);
      chk("t1_cea_last", mem_cea, 1);
      chk("t1_ada_last", mem_ada, 3);
      chk("t1_din_last", mem_din, 8'h09);
      chk("t1_ready_run", boot_ready, 0);
      step;
      @(negedge clk);
      chk("t1_done", boot_done, 1);
      chk("t1_cea_idle", mem_cea, 0);
      step;

      // 2: CPU reads 0..3 back-to-back
      for (int k = 0; k < 6; k++) begin
         cpu_rd_req = (k < 4); cpu_rd_addr = AW'(k);
         @(negedge clk);
         chk("t2_gnt", cpu_rd_gnt, (k < 4));
         chk("t2_ceb", mem_ceb, (k < 4));
         if (k < 4) chk("t2_adb", mem_adb, k);
         chk("t2_valid", cpu_rd_valid, (k >= 2));
         if (k >= 2) chk("t2_data", cpu_rd_data, 8'h06 + k - 2);
         chk("t2_lcd_valid", lcd_rd_valid, 0);
         step;
      end
      @(negedge clk);
      chk("t2_hold_valid", cpu_rd_valid, 0);
      chk("t2_hold_data", cpu_rd_data, 8'h09);
      step;

      // 3: one LCD read, then both request every cycle
      for (int j = 0; j < 9; j++) begin
         lcd_rd_req = (j <= 6); cpu_rd_req = (j >= 1 && j <= 6);
         lcd_rd_addr = (j == 0) ? AW'(1) : AW'(3); cpu_rd_addr = 0;
         cg = (j >= 1 && j <= 6 && (j % 2) == 1);
         lg = (j == 0) || (j >= 2 && j <= 6 && (j % 2) == 0);
         g  = j - 2;
         cv = (g >= 1 && (g % 2) == 1);
         lv = (g == 0) || (g >= 2 && (g % 2) == 0);
         @(negedge clk);
         chk("t3_cpu_gnt", cpu_rd_gnt, cg);
         chk("t3_lcd_gnt", lcd_rd_gnt, lg);
         chk("t3_ceb", mem_ceb, cg | lg);
         if (cg | lg) chk("t3_adb", mem_adb, cg ? 0 : ((j == 0) ? 1 : 3));
         chk("t3_cpu_valid", cpu_rd_valid, cv);
         chk("t3_lcd_valid", lcd_rd_valid, lv);
         if (cv) chk("t3_cpu_data", cpu_rd_data, 8'h06);
         if (lv) chk("t3_lcd_data", lcd_rd_data, (g == 0) ? 8'h07 : 8'h09);
         step;
      end

      // 4: reboot with gaps; LCD request held pending through boot
      rst_n = 0; cpu_rd_req = 0; lcd_rd_req = 0;
      step;
      rst_n = 1; lcd_rd_req = 1; lcd_rd_addr = 1;
      for (int k = 0; k < 6; k++) begin
         boot_valid = ((k % 2) == 0 && k <= 4);
         boot_data  = boot_valid ? DW'(8'hA0 + k / 2) : 8'hFF;
         boot_last  = (k == 4);
         @(negedge clk);
         if (k == 0) chk("t4_lcd_data_rst", lcd_rd_data, 0);
         chk("t4_cea", mem_cea, (k >= 1 && ((k - 1) % 2) == 0));
         if (k >= 1 && ((k - 1) % 2) == 0) begin
            chk("t4_ada", mem_ada, (k - 1) / 2);
            chk("t4_din", mem_din, 8'hA0 + (k - 1) / 2);
         end
         chk("t4_lcd_gnt", lcd_rd_gnt, (k == 5));
         if (k == 5) chk("t4_adb", mem_adb, 1);
         step;
      end
      lcd_rd_req = 0; boot_valid = 0; boot_last = 0;
      @(negedge clk);
      chk("t4_done", boot_done, 1);
      chk("t4_lcd_valid0", lcd_rd_valid, 0);
      step;
      @(negedge clk);
      chk("t4_lcd_valid", lcd_rd_valid, 1);
      chk("t4_lcd_data", lcd_rd_data, 8'hA1);
      step;

      // 6: reset after two boot bytes, then with a read in flight
      rst_n = 0;
      step;
      rst_n = 1;
      for (int i = 0; i < 2; i++) begin
         boot_valid = 1; boot_data = DW'(8'h11 + i);
         step;
      end
      boot_valid = 0; rst_n = 0;
      step;
      rst_n = 1;
      for (int i = 0; i < 2; i++) begin
         boot_valid = 1; boot_data = DW'(8'h21 + i); boot_last = (i == 1);
         @(negedge clk);
         chk("t6_ready", boot_ready, 1);
         chk("t6_done0", boot_done, 0);
         if (i == 1) begin
            chk("t6_cea", mem_cea, 1);
            chk("t6_ada", mem_ada, 0);
            chk("t6_din", mem_din, 8'h21);
         end
         step;
      end
      boot_valid = 0; boot_last = 0;
      @(negedge clk);
      chk("t6_ada2", mem_ada, 1);
      chk("t6_din2", mem_din, 8'h22);
      step;
      cpu_rd_req = 1; cpu_rd_addr = 0;
      @(negedge clk);
      chk("t6_gnt", cpu_rd_gnt, 1);
      step;
      cpu_rd_req = 0; rst_n = 0;
      step;
      rst_n = 1;
      @(negedge clk);
      chk("t6_no_valid", cpu_rd_valid, 0);
      chk("t6_reboot_ready", boot_ready, 1);
      chk("t6_reboot_done", boot_done, 0);
      step;
      @(negedge clk);
      chk("t6_no_valid2", cpu_rd_valid, 0);
      step;

      // 5: boot near top of memory without last
      for (int k = 0; k < 4; k++) begin
         b_valid = (k < 3); b_data = DW'(8'hC0 + k); b_last = 0;
         @(negedge clk);
         case (k)
            0: begin
               chk("t5_ready", b_ready, 1);
               chk("t5_cea0", b_cea, 0);
            end
            1: begin
               chk("t5_cea1", b_cea, 1);
               chk("t5_ada1", b_ada, 13'h1FFE);
               chk("t5_din1", b_din, 8'hC0);
            end
            2: begin
               chk("t5_cea2", b_cea, 1);
               chk("t5_ada2", b_ada, 13'h1FFF);
               chk("t5_din2", b_din, 8'hC1);
               chk("t5_ovf", b_ovf, 1);
               chk("t5_ready_run", b_ready, 0);
            end
            default: begin
               chk("t5_no_third", b_cea, 0);
               chk("t5_ovf_sticky", b_ovf, 1);
               chk("t5_done", b_done, 1);
            end
         endcase
         step;
      end
      b_valid = 0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
